// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift register bank: mode encodings and the
// shift-counter width helper.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Bits needed to hold a count running from 0 up to and including max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/shift_cnt.sv
// Saturating shift counter with clear and a registered one-cycle pulse on
// the increment that reaches MAX.
module shift_cnt
  import shift_reg_pkg::*;
#(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tick_o
);

  localparam int unsigned W = cnt_width(MAX);
  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  // Clear wins over increment; the pulse defaults low on every edge.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (en_i) begin
      if (clr_i) begin
        cnt_d = '0;
      end else if (inc_i && (cnt_q < MAX_C)) begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = (cnt_q == (MAX_C - 1'b1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/shift_reg_bank.sv
// WIDTH-bit shift/hold/load register with serial outputs and a done pulse
// after WIDTH shifts since the last load or reset.
module shift_reg_bank
  import shift_reg_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sl_in,
  input  logic             sr_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             so_left,
  output logic             so_right,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  mode_e            mode_sel;
  logic             is_shift;
  logic             is_load;

  assign mode_sel = mode_e'(mode);
  assign is_shift = (mode_sel == MODE_SHL) || (mode_sel == MODE_SHR);
  assign is_load  = (mode_sel == MODE_LOAD);

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode_sel)
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], sl_in};
        MODE_SHR:  q_d = {sr_in, q_q[WIDTH-1:1]};
        MODE_LOAD: q_d = d;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RESET_VAL;
    else        q_q <= q_d;
  end

  shift_cnt #(
    .MAX (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .clr_i  (is_load),
    .inc_i  (is_shift),
    .tick_o (done)
  );

  assign q        = q_q;
  assign nq       = ~q_q;
  assign so_left  = q_q[WIDTH-1];
  assign so_right = q_q[0];

endmodule

// File: doc/shift_reg_bank.md
# shift_reg_bank

Parametrised synchronous shift/hold register that extends the lab's single-bit storage elements to a WIDTH-bit clocked register. It supports parallel load, left and right shift, and hold modes. A saturating shift counter flags when a full word has been serialised. It sits between the lab's switch/LED I/O and the serial blocks, acting as a parallel-to-serial and serial-to-parallel converter.

## Interface
- WIDTH, 8, data width; legal range 2..32
- RESET_VAL, 0, value loaded into q on reset
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- en  in  1  clock enable; 0 = every register holds
- mode  in  2  00 hold, 01 shift left, 10 shift right, 11 parallel load
- d  in  WIDTH  parallel load data
- sl_in  in  1  serial input, enters q[0] on shift left
- sr_in  in  1  serial input, enters q[WIDTH-1] on shift right
- q  out  WIDTH  register contents
- nq  out  WIDTH  bitwise complement of q, always ~q
- so_left  out  1  q[WIDTH-1] (bit leaving on the next left shift)
- so_right  out  1  q[0] (bit leaving on the next right shift)
- done  out  1  one-cycle pulse: WIDTH shifts completed since last load/reset

## Operation
- Reset (rst_n=0, any time, asynchronous):
  - q=RESET_VAL, nq=~RESET_VAL
  - shift count=0, done=0
- en=0: q, count and done-source hold; done is driven 0 on the next edge.
- en=1, mode 00 (hold): q and count unchanged; done=0.
- en=1, mode 01 (shift left): q <= {q[WIDTH-2:0], sl_in}.
- en=1, mode 10 (shift right): q <= {sr_in, q[WIDTH-1:1]}.
- en=1, mode 11 (load): q <= d; count <= 0; done=0.
- Shift counter:
  - width $clog2(WIDTH+1).
  - Each shift (left or right, mixed freely) increments count while count<WIDTH.
  - Saturates at WIDTH; further shifts still move data but leave count at WIDTH.
- done:
  - registered; 1 for exactly one cycle after the edge on which count goes WIDTH-1 -> WIDTH.
  - Never re-asserts until a load or reset clears count.
- nq, so_left and so_right are combinational from q; no extra latency.
- Simultaneous events:
  - reset dominates everything.
  - load dominates count increment.
  - Data inputs are sampled only in the selected mode; unused inputs are ignored.

## Timing
- Load/shift latency 1 cycle: q reflects the new value after the capturing rising edge.
- done latency: high in the cycle after the WIDTH-th shift edge, low on the following edge regardless of inputs.
- Reset release is synchronised by the caller. The first capturing edge is the first rising clk with rst_n=1.
- Reset during a shift sequence aborts it: count=0, no done pulse.
- Back-to-back loads are legal every cycle.
- A shift directly after a load counts as shift 1.

## Structure
- Shared package shift_reg_pkg:
  - mode encodings MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10, MODE_LOAD=2'b11
  - function for counter width
- Sub-module shift_cnt: saturating counter with clear, increment, terminal-pulse output, parametrised by MAX=WIDTH.
- Top holds the data register and mode mux, and instantiates one shift_cnt.

## Test plan
- Reset with RESET_VAL=8'hA5, clk running: q=8'hA5, nq=8'h5A, done=0. Mid-shift reset returns q=8'hA5 asynchronously, before the next edge.
- Load d=8'h81, then 8 left shifts with sl_in=0:
  - q sequence 02,04,08,10,20,40,80,00.
  - so_left sequence before each edge 1,0,0,0,0,0,0,1.
  - done high only in the cycle after the 8th shift.
- Load 8'h01, then 8 right shifts with sr_in=1:
  - q=8'hFF at the end.
  - done pulses once; a 9th and 10th shift give no further done.
- Load 8'h3C; alternate en=0/en=1 with mode 01, sl_in=1:
  - q changes only on en=1 edges.
  - done after the 8th enabled shift, not before.
- Mixed directions: load, then 4 left + 4 right shifts give done on the 8th. A load on shift 7 clears count, so the next done needs 8 further shifts.
- Hold mode for 5 cycles after load 8'hC3: q stays 8'hC3, nq stays 8'h3C, count unchanged, done=0.
